// File: rtl/tff_count_ctrl_pkg.sv
// Shared types for the T-FF counter sequencer: FSM state encoding and default width.
package tff_count_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int DEF_WIDTH = 4;

endpackage

// File: rtl/tff_count_ctrl_if.sv
// Start/done handshake and count bus between a requester and the T-FF counter sequencer.
interface tff_count_ctrl_if #(parameter int WIDTH = tff_count_ctrl_pkg::DEF_WIDTH);
  logic             start;
  logic             up;
  logic [WIDTH-1:0] limit;
  logic             hold;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (output start, up, limit, hold, abort, input count, busy, done);
  modport slave  (input start, up, limit, hold, abort, output count, busy, done);
endinterface

// File: rtl/tff_count_ctrl_cell.sv
// Single toggle flip-flop: q flips on every edge where t is high, async clear to 0.
module tff_cell (
  input  logic t,
  input  logic clk,
  input  logic reset,
  output logic q
);

  always_ff @(posedge clk or posedge reset)
    if (reset) q <= 1'b0;
    else       q <= q ^ t;

endmodule

// File: rtl/tff_count_ctrl.sv
// Programmable up/down counter built from a bank of T-FF cells; the FSM here only
// computes the per-cell toggle vector, the cells themselves hold the count.
module tff_count_ctrl
  import tff_count_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic            clk,
  input  logic            reset,
  tff_count_ctrl_if.slave bus
);

  state_e           state;
  logic             up_r;
  logic [WIDTH-1:0] limit_r;
  logic             busy_r, done_r;
  logic [WIDTH-1:0] q, t_vec, step, init, endv;
  logic             at_end;

  assign init   = up_r ? '0 : limit_r;
  assign endv   = up_r ? limit_r : '0;
  assign at_end = (q == endv);

  // Bit i toggles when all lower bits are 1 (up) or all 0 (down).
  assign step[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_step
    assign step[i] = up_r ? &q[i-1:0] : &(~q[i-1:0]);
  end

  always_comb begin
    t_vec = '0;
    if (state == S_LOAD && !bus.abort)
      t_vec = q ^ init;
    else if (state == S_RUN && !bus.abort && !at_end && !bus.hold)
      t_vec = step;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .t     (t_vec[i]),
      .clk   (clk),
      .reset (reset),
      .q     (q[i])
    );
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= S_IDLE;
      up_r    <= 1'b0;
      limit_r <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            up_r    <= bus.up;
            limit_r <= bus.limit;
            state   <= S_LOAD;
            busy_r  <= 1'b1;
          end
        end
        S_LOAD: begin
          state  <= bus.abort ? S_IDLE : S_RUN;
          busy_r <= !bus.abort;
        end
        S_RUN: begin
          // Abort outranks the terminal test; terminal outranks hold.
          if (bus.abort) begin
            state  <= S_IDLE;
            busy_r <= 1'b0;
          end else if (at_end) begin
            state  <= S_DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          done_r <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end

  assign bus.count = q;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;

endmodule
